// File: rtl/mips_pkg.sv
// Shared fetch/decode definitions: datapath width, bubble word and the
// instruction/nextpc pair carried from fetch into decode.
package mips_pkg;

   localparam int          DATA_W   = 32;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [DATA_W-1:0] nextpc;
   } if_id_entry_t;

endpackage

// File: rtl/if_id_ptr_ctrl.sv
// Read/write pointers, occupancy count and full/empty decode for the
// fetch-to-decode queue; a flush rewinds everything to zero.
module if_id_ptr_ctrl #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hit,
   input  logic                     pc_src,
   input  logic                     id_stall,
   output logic [$clog2(DEPTH)-1:0] rd_ptr,
   output logic [$clog2(DEPTH)-1:0] wr_ptr,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     enq
);

   localparam int PTR_W = $clog2(DEPTH);

   logic deq;

   assign empty = (count == '0);
   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign enq   = hit & ~full & ~pc_src;
   assign deq   = ~empty & ~id_stall & ~pc_src;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (pc_src) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         if (enq && !deq)
            count <= count + 1'b1;
         else if (deq && !enq)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue with back-pressure and branch flush.
// Optional perf counters (bubble_cnt, flush_cnt) when IF_ID_PERF_EN is defined.
module if_id_queue #(
   parameter int                DEPTH    = 2,
   parameter int                DATA_W   = mips_pkg::DATA_W,
   parameter logic [DATA_W-1:0] NOP_WORD = mips_pkg::NOP_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] instruction,
   input  logic [DATA_W-1:0] nextpc,
   input  logic              hit,
   input  logic              pc_src,
   input  logic              id_stall,
   output logic [DATA_W-1:0] id_instruction,
   output logic [DATA_W-1:0] id_nextpc,
   output logic              id_valid,
   output logic              fetch_stall
`ifdef IF_ID_PERF_EN
   ,
   output logic [31:0]       bubble_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   import mips_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             empty;
   logic             full;
   logic             enq;

   if_id_entry_t     mem [DEPTH];
   if_id_entry_t     head;

   if_id_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
      .clk      (clk),
      .rst      (rst),
      .hit      (hit),
      .pc_src   (pc_src),
      .id_stall (id_stall),
      .rd_ptr   (rd_ptr),
      .wr_ptr   (wr_ptr),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .enq      (enq)
   );

   // Storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[wr_ptr] <= '{instr: instruction, nextpc: nextpc};
      end
   end

   assign head           = mem[rd_ptr];
   assign id_valid       = ~empty;
   assign fetch_stall    = full;
   assign id_instruction = id_valid ? head.instr  : NOP_WORD;
   assign id_nextpc      = id_valid ? head.nextpc : '0;

`ifdef IF_ID_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (!id_valid && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + 1'b1;
         if (pc_src && flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_if_id_queue;

   localparam int DEPTH = 2;

   typedef struct {
      logic [31:0] i;
      logic [31:0] n;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instruction = '0;
   logic [31:0] nextpc = '0;
   logic        hit = 1'b0;
   logic        pc_src = 1'b0;
   logic        id_stall = 1'b0;
   logic [31:0] id_instruction;
   logic [31:0] id_nextpc;
   logic        id_valid;
   logic        fetch_stall;
`ifdef IF_ID_PERF_EN
   logic [31:0] bubble_cnt;
   logic [31:0] flush_cnt;
`endif

   int   n_cmp = 0;
   int   n_bad = 0;
   bit   chk_en = 1'b0;
   ent_t exp_q[$];

   if_id_queue #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .instruction    (instruction),
      .nextpc         (nextpc),
      .hit            (hit),
      .pc_src         (pc_src),
      .id_stall       (id_stall),
      .id_instruction (id_instruction),
      .id_nextpc      (id_nextpc),
      .id_valid       (id_valid),
`ifdef IF_ID_PERF_EN
      .bubble_cnt     (bubble_cnt),
      .flush_cnt      (flush_cnt),
`endif
      .fetch_stall    (fetch_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // One cycle of fetch/decode activity; the model decides from the
   // occupancy seen before the edge, after the monitor has retired the head.
   task automatic step(input bit h, input logic [31:0] ins,
                       input logic [31:0] np, input bit pc, input bit st);
      bit was_full;
      @(negedge clk);
      #1;
      hit         = h;
      instruction = ins;
      nextpc      = np;
      pc_src      = pc;
      id_stall    = st;
      was_full    = (exp_q.size() == DEPTH);
      #2;
      if (pc)
         exp_q.delete();
      else if (h && !was_full)
         exp_q.push_back('{ins, np});
   endtask

   // Monitor: checks the presented outputs and pops whenever decode accepts.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (chk_en) begin
            chk("id_valid", 32'(id_valid), 32'(exp_q.size() != 0));
            chk("fetch_stall", 32'(fetch_stall),
                32'(exp_q.size() == DEPTH));
            if (exp_q.size() != 0) begin
               chk("id_instruction", id_instruction, exp_q[0].i);
               chk("id_nextpc", id_nextpc, exp_q[0].n);
               if (!id_stall && !pc_src)
                  void'(exp_q.pop_front());
            end else begin
               chk("nop_instruction", id_instruction, 32'h0);
               chk("nop_nextpc", id_nextpc, 32'h0);
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk_en = 1'b1;

      // single pass then bubble
      step(1, 32'h2008_0005, 32'h4, 0, 0);
      step(0, 32'h0, 32'h0, 0, 0);
      step(0, 32'h0, 32'h0, 0, 0);

      // fill and back-pressure: C is blocked, then re-presented
      step(1, 32'hAAAA_0001, 32'h8, 0, 1);
      step(1, 32'hBBBB_0002, 32'hC, 0, 1);
      step(1, 32'hCCCC_0003, 32'h10, 0, 1);
      step(1, 32'hCCCC_0003, 32'h10, 0, 0);
      step(1, 32'hCCCC_0003, 32'h10, 0, 0);
      step(0, 32'h0, 32'h0, 0, 0);
      step(0, 32'h0, 32'h0, 0, 0);
      step(0, 32'h0, 32'h0, 0, 0);

      // flush priority over enq and deq
      step(1, 32'hAAAA_0001, 32'h14, 0, 1);
      step(1, 32'hBBBB_0002, 32'h18, 0, 1);
      step(1, 32'hDDDD_0004, 32'h1C, 1, 0);
      step(0, 32'h0, 32'h0, 0, 0);

      // wrap-around: back-to-back enq/deq
      for (int k = 1; k <= 10; k++)
         step(1, 32'h1000_0000 + 32'(k), 32'(4 * k), 0, 0);
      step(0, 32'h0, 32'h0, 0, 0);
      step(0, 32'h0, 32'h0, 0, 0);

      // random traffic
      for (int k = 0; k < 3000; k++)
         step($urandom_range(3, 0) != 0, $urandom, $urandom,
              $urandom_range(15, 0) == 0, $urandom_range(9, 0) < 4);

      // asynchronous reset with two entries held
      step(1, 32'h1111_1111, 32'h20, 1, 1);
      step(1, 32'h2222_2222, 32'h24, 0, 1);
      step(1, 32'h3333_3333, 32'h28, 0, 1);
      step(0, 32'h0, 32'h0, 0, 1);
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      chk("pre_rst_valid", 32'(id_valid), 32'h1);
      rst = 1'b1;
      #1;
      chk("rst_valid", 32'(id_valid), 32'h0);
      chk("rst_fetch_stall", 32'(fetch_stall), 32'h0);
      chk("rst_instruction", id_instruction, 32'h0);
      chk("rst_nextpc", id_nextpc, 32'h0);
      exp_q.delete();
      hit = 1'b0;
      id_stall = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk_en = 1'b1;
      step(1, 32'h2008_0005, 32'h4, 0, 0);
      step(0, 32'h0, 32'h0, 0, 0);
      step(0, 32'h0, 32'h0, 0, 0);

      @(negedge clk);
      #4;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
               n_bad);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling buffer between the fetch stage and decode. It sits directly downstream of the fetch unit and consumes its instruction, nextpc and hit outputs.
- Holds up to DEPTH fetched instructions with their PC+4 values, presents the oldest to decode, and back-pressures fetch when full.
- Discards all contents when a taken branch (pc_src) redirects fetch.

Parameters:
- DEPTH, 2, number of entries; power of two, minimum 2.
- DATA_W, 32, width of instruction and nextpc fields.
- NOP_WORD, 32'h0000_0000, value driven on id_instruction when no entry is valid.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- instruction  input  DATA_W  instruction word from fetch.
- nextpc  input  DATA_W  PC+4 from fetch.
- hit  input  1  fetch word valid (cache hit) this cycle.
- pc_src  input  1  branch taken / flush request.
- id_stall  input  1  decode cannot accept this cycle.
- id_instruction  output  DATA_W  oldest buffered instruction, or NOP_WORD.
- id_nextpc  output  DATA_W  nextpc paired with id_instruction, or 0.
- id_valid  output  1  id_instruction/id_nextpc are meaningful.
- fetch_stall  output  1  queue full; fetch must hold PC.

Behaviour:
- Storage: circular array of DEPTH entries {instruction, nextpc}. Pointers rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Reset (async, rst=1): rd_ptr=wr_ptr=0, count=0, id_valid=0, id_instruction=NOP_WORD, id_nextpc=0, fetch_stall=0. Storage contents are don't-care.
- Occupancy states are derived from count:
  - EMPTY (count=0)
  - PARTIAL (0<count<DEPTH)
  - FULL (count=DEPTH)
- Output rules:
  - id_valid = (count!=0).
  - fetch_stall = (count==DEPTH).
  - Both are decoded from registers only; there is no combinational path from any input to any output.
  - id_instruction/id_nextpc = head entry when id_valid, else NOP_WORD/0.
- Enqueue condition: enq = hit & !fetch_stall & !pc_src.
- Dequeue condition: deq = id_valid & !id_stall & !pc_src.
- Latency: a word enqueued at edge N appears on id_* after edge N when the queue was empty (1 cycle from hit to id_valid).
- Simultaneous enq and deq in PARTIAL: both pointers advance, count is unchanged.
- FULL with deq: enqueue is blocked in the same cycle because fetch_stall=1. Fetch retries next cycle; no loss because fetch holds PC.
- EMPTY: deq cannot occur and id_stall is ignored.
- Flush (pc_src=1 at an edge): count=0 and rd_ptr=wr_ptr=0. The incoming word is discarded and the head is not consumed. Flush has priority over enq/deq.
- hit=0: no enqueue. This is a miss bubble, and decode sees id_valid=0 once the queue drains.
- Reset asserted mid-operation: state clears immediately (asynchronously), without waiting for a clock edge.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- When defined:
  - Adds output ports bubble_cnt (32) and flush_cnt (32), both reset to 0.
  - bubble_cnt increments on every cycle with id_valid=0 and rst=0.
  - flush_cnt increments on every edge with pc_src=1.
  - Both counters saturate at 32'hFFFF_FFFF.
- When undefined: the ports and logic are absent and the queue behaviour is identical.

Decomposition:
- Shared package mips_pkg: DATA_W, NOP_WORD, and a struct if_id_entry_t {instr, nextpc}.
- One sub-module: if_id_ptr_ctrl, which owns rd_ptr, wr_ptr, count, and the full/empty decode.
- The top level holds the storage array and the output mux.

Test Plan:
- Reset: rst=1 mid-run with count=2 -> outputs immediately read id_valid=0, fetch_stall=0, id_instruction=0, id_nextpc=0.
- Single pass: hit=1, instruction=32'h2008_0005, nextpc=32'h4, id_stall=0 -> next cycle id_valid=1, id_instruction=32'h2008_0005, id_nextpc=32'h4; following cycle (hit=0) id_valid=0.
- Fill and back-pressure: id_stall=1, hit=1 for 3 cycles with words A,B,C -> after 2 edges fetch_stall=1 and C is not stored. Then id_stall=0 -> decode sees A, then B, and C once fetch re-presents it.
- Flush priority: queue holds A,B; pc_src=1, hit=1 with D, id_stall=0 -> next cycle id_valid=0 and count=0; D is lost and A is not counted as consumed.
- Wrap-around: 10 consecutive enq/deq pairs with nextpc 4..40 -> id_nextpc sequence is exact, with no duplication or skips across pointer wrap.
- Perf (IF_ID_PERF_EN defined): 3 miss cycles on an empty queue and 1 flush -> bubble_cnt=3, flush_cnt=1.
